// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA frame adapter: 640x480@60 scan timing
// and the 160x120 framebuffer geometry.
package vga_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [7:0] FB_WIDTH    = 8'd160;
    localparam logic [6:0] FB_HEIGHT   = 7'd120;
    localparam int         SCALE_SHIFT = 2;

    localparam int                   FB_DEPTH  = 19200;
    localparam int                   FB_ADDR_W = 15;
    localparam logic [FB_ADDR_W-1:0] FB_LAST   = FB_ADDR_W'(FB_DEPTH - 1);
    localparam logic [FB_ADDR_W-1:0] FB_END    = FB_ADDR_W'(FB_DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } clear_state_t;

    // row*160 + col without a multiplier; row may exceed 119 on the scan side
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] row,
                                                     input logic [7:0] col);
        logic [FB_ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 7) + (r << 5) + {7'd0, col};
    endfunction

endpackage

// File: rtl/vga_frame_adapter_if.sv
// Plot port between the game logic (master) and the frame adapter (slave).
interface vga_frame_adapter_if;

    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic       busy;

    modport master (output colour, output x, output y, output plot, input busy);
    modport slave  (input colour, input x, input y, input plot, output busy);

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider and 640x480@60 scan counters; emits undelayed sync/visible
// and the framebuffer cell coordinates for the pixel being scanned.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       vga_clk,
    output logic [7:0] fb_col,
    output logic [7:0] fb_row,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       visible
);

    logic [9:0] hcount;
    logic [9:0] vcount;

    // Counters advance on the half-cycle where vga_clk is high, so they are
    // settled by the time the pin-level VGA_CLK rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_clk <= 1'b0;
            hcount  <= '0;
            vcount  <= '0;
        end else begin
            vga_clk <= ~vga_clk;
            if (vga_clk) begin
                if (hcount == H_TOTAL - 10'd1) begin
                    hcount <= '0;
                    vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign pix_en  = vga_clk;
    assign fb_col  = 8'(hcount >> SCALE_SHIFT);
    assign fb_row  = 8'(vcount >> SCALE_SHIFT);
    assign hs_raw  = !(hcount >= H_SYNC_START && hcount < H_SYNC_END);
    assign vs_raw  = !(vcount >= V_SYNC_START && vcount < V_SYNC_END);
    assign visible = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

endmodule

// File: rtl/vga_frame_adapter.sv
// 160x120x3 framebuffer with a plot port, post-reset clear sweep and 4x-scaled
// 640x480@60 VGA scanout.
module vga_frame_adapter
    import vga_pkg::*;
#(
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst,
    vga_frame_adapter_if.slave        bus,
    output logic                      VGA_CLK,
    output logic                      VGA_HS,
    output logic                      VGA_VS,
    output logic                      VGA_BLANK_N,
    output logic                      VGA_SYNC_N,
    output logic [9:0]                VGA_R,
    output logic [9:0]                VGA_G,
    output logic [9:0]                VGA_B
);

    logic [2:0]           fb_ram [FB_DEPTH];

    clear_state_t         state;
    clear_state_t         next_state;
    logic [FB_ADDR_W-1:0] clear_addr;
    logic                 we;
    logic [FB_ADDR_W-1:0] wa;
    logic [2:0]           wd;
    logic [FB_ADDR_W-1:0] plot_addr;
    logic                 plot_ok;

    logic                 pix_en;
    logic [7:0]           fb_col;
    logic [7:0]           fb_row;
    logic                 hs_raw;
    logic                 vs_raw;
    logic                 visible;
    logic [FB_ADDR_W-1:0] rd_addr;
    logic [2:0]           rd_colour;
    logic                 hs_q;
    logic                 vs_q;
    logic                 blank_n_q;

    vga_timing_gen u_timing (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .vga_clk (VGA_CLK),
        .fb_col  (fb_col),
        .fb_row  (fb_row),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw),
        .visible (visible)
    );

    assign plot_addr = fb_addr({1'b0, bus.y}, bus.x);
    assign plot_ok   = bus.plot && (bus.x < FB_WIDTH) && (bus.y < FB_HEIGHT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
        end else begin
            state <= next_state;
            if (state == ST_CLEAR) begin
                clear_addr <= clear_addr + 1'b1;
            end
        end
    end

    // The sweep owns the write port until its last address; plots only get it in IDLE.
    always_comb begin
        next_state = state;
        bus.busy   = 1'b0;
        we         = 1'b0;
        wa         = plot_addr;
        wd         = bus.colour;
        unique case (state)
            ST_CLEAR: begin
                bus.busy = 1'b1;
                we       = !rst;
                wa       = clear_addr;
                wd       = CLEAR_COLOUR;
                if (clear_addr == FB_LAST) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                we = plot_ok && !rst;
            end
            default: next_state = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            fb_ram[wa] <= wd;
        end
    end

    assign rd_addr = fb_addr(fb_row, fb_col);

    // Blanking-region addresses run past the array; those reads are skipped.
    always_ff @(posedge clk) begin
        if (pix_en && rd_addr < FB_END) begin
            rd_colour <= fb_ram[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en) begin
            hs_q      <= hs_raw;
            vs_q      <= vs_raw;
            blank_n_q <= visible;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = blank_n_q ? {10{rd_colour[2]}} : 10'd0;
    assign VGA_G       = blank_n_q ? {10{rd_colour[1]}} : 10'd0;
    assign VGA_B       = blank_n_q ? {10{rd_colour[0]}} : 10'd0;

endmodule

// File: tb/tb_vga_frame_adapter.sv
// Directed bench for vga_frame_adapter: clear sweep, plot/scanout, bounds,
// sync placement and mid-frame reset, with a non-zero clear colour.
module tb_vga_frame_adapter;

    localparam logic [2:0]  CLR   = 3'b101;
    localparam logic [31:0] C_EXP = {2'b00, 10'h3FF, 10'h000, 10'h3FF};
    localparam logic [31:0] G_EXP = {2'b00, 10'h000, 10'h3FF, 10'h000};
    localparam int K_PIX   = 0;
    localparam int K_HS    = 1;
    localparam int K_VS    = 2;
    localparam int K_BLANK = 3;

    typedef struct {
        int          h;
        int          v;
        int          kind;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [9:0] VGA_R;
    logic [9:0] VGA_G;
    logic [9:0] VGA_B;

    int compare_count  = 0;
    int mismatch_count = 0;
    int edge_cnt       = 0;

    vga_frame_adapter_if plot_bus ();

    vga_frame_adapter #(.CLEAR_COLOUR(CLR)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (plot_bus),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Clock edges since the last edge that sampled rst high.
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic [7:0] px,
                                 input logic [6:0] py, input logic [2:0] pc);
        plot_bus.plot   = p;
        plot_bus.x      = px;
        plot_bus.y      = py;
        plot_bus.colour = pc;
    endtask

    function automatic logic [31:0] rgb();
        return {2'b00, VGA_R, VGA_G, VGA_B};
    endfunction

    // Outputs for pixel p are registered at edge 2p+2 counted from reset release.
    task automatic waitPixel(input int h, input int v);
        int target;
        target = 2 * (v * 800 + h) + 2;
        while (edge_cnt < target) @(negedge clk);
    endtask

    vec_t vecs[$];
    int   busy_cycles;
    int   n;
    int   low_n;
    int   guard;
    logic [31:0] obs;

    initial begin
        vecs.push_back('{0,   13, K_PIX,   C_EXP, "clear_l13"});
        vecs.push_back('{639, 15, K_PIX,   C_EXP, "clear_l15_end"});
        vecs.push_back('{80,  15, K_PIX,   C_EXP, "nb_above"});
        vecs.push_back('{79,  16, K_PIX,   C_EXP, "nb_left"});
        vecs.push_back('{80,  16, K_PIX,   G_EXP, "plot_tl"});
        vecs.push_back('{83,  16, K_PIX,   G_EXP, "plot_tr"});
        vecs.push_back('{84,  16, K_PIX,   C_EXP, "nb_right"});
        vecs.push_back('{81,  17, K_PIX,   G_EXP, "plot_mid"});
        vecs.push_back('{83,  19, K_PIX,   G_EXP, "plot_br"});
        vecs.push_back('{80,  20, K_PIX,   C_EXP, "nb_below"});
        vecs.push_back('{639, 21, K_BLANK, 32'd1, "blank_last_vis"});
        vecs.push_back('{640, 21, K_BLANK, 32'd0, "blank_first_fp"});
        vecs.push_back('{640, 21, K_PIX,   32'd0, "rgb_in_blank"});
        vecs.push_back('{655, 21, K_HS,    32'd1, "hs_before"});
        vecs.push_back('{656, 21, K_HS,    32'd0, "hs_start"});
        vecs.push_back('{751, 21, K_HS,    32'd0, "hs_last"});
        vecs.push_back('{752, 21, K_HS,    32'd1, "hs_after"});
        vecs.push_back('{0,   22, K_VS,    32'd1, "vs_visible"});
        vecs.push_back('{0,   24, K_PIX,   C_EXP, "bounds_x160"});
        vecs.push_back('{120, 24, K_PIX,   C_EXP, "busy_plot_dropped"});
        vecs.push_back('{3,   27, K_PIX,   C_EXP, "bounds_x160_br"});

        applyStimulus(1'b0, 8'd0, 7'd0, 3'b000);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("rst_hs",    {31'd0, VGA_HS}, 32'd1);
        checkOutput("rst_vs",    {31'd0, VGA_VS}, 32'd1);
        checkOutput("rst_blank", {31'd0, VGA_BLANK_N}, 32'd0);
        checkOutput("rst_rgb",   rgb(), 32'd0);
        checkOutput("rst_vgaclk", {31'd0, VGA_CLK}, 32'd0);
        checkOutput("rst_busy",  {31'd0, plot_bus.busy}, 32'd1);
        checkOutput("sync_n",    {31'd0, VGA_SYNC_N}, 32'd1);

        rst = 1'b0;
        busy_cycles = 0;
        while (plot_bus.busy && busy_cycles < 25000) begin
            busy_cycles++;
            if (busy_cycles == 15000) applyStimulus(1'b1, 8'd30, 7'd6, 3'b010);
            else                      applyStimulus(1'b0, 8'd0, 7'd0, 3'b000);
            @(negedge clk);
        end
        checkOutput("busy_len", busy_cycles, 32'd19200);

        applyStimulus(1'b1, 8'd20, 7'd4, 3'b010);
        @(negedge clk);
        applyStimulus(1'b1, 8'd160, 7'd5, 3'b111);
        @(negedge clk);
        applyStimulus(1'b1, 8'd0, 7'd120, 3'b111);
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 7'd0, 3'b000);

        foreach (vecs[i]) begin
            waitPixel(vecs[i].h, vecs[i].v);
            case (vecs[i].kind)
                K_HS:    obs = {31'd0, VGA_HS};
                K_VS:    obs = {31'd0, VGA_VS};
                K_BLANK: obs = {31'd0, VGA_BLANK_N};
                default: obs = rgb();
            endcase
            checkOutput(vecs[i].tag, obs, vecs[i].exp);
        end

        guard = 0;
        while (VGA_HS && guard < 4000) begin @(negedge clk); guard++; end
        n = 0;
        while (!VGA_HS && n < 4000) begin @(negedge clk); n++; end
        low_n = n;
        while (VGA_HS && n < 4000) begin @(negedge clk); n++; end
        checkOutput("hs_low_clk", low_n, 32'd192);
        checkOutput("line_period_clk", n, 32'd1600);

        waitPixel(100, 29);
        checkOutput("pre_rst_blank", {31'd0, VGA_BLANK_N}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_hs",     {31'd0, VGA_HS}, 32'd1);
        checkOutput("mid_rst_vs",     {31'd0, VGA_VS}, 32'd1);
        checkOutput("mid_rst_blank",  {31'd0, VGA_BLANK_N}, 32'd0);
        checkOutput("mid_rst_rgb",    rgb(), 32'd0);
        checkOutput("mid_rst_vgaclk", {31'd0, VGA_CLK}, 32'd0);
        checkOutput("mid_rst_busy",   {31'd0, plot_bus.busy}, 32'd1);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("restart_e1_blank", {31'd0, VGA_BLANK_N}, 32'd0);
        @(negedge clk);
        checkOutput("restart_px0_blank", {31'd0, VGA_BLANK_N}, 32'd1);
        checkOutput("restart_busy", {31'd0, plot_bus.busy}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
